// File: rtl/panel_debounce.sv
// panel_debounce: synchronises the multiplexed front-panel switch nibble and
// debounces each of the 8 scan slots independently. io_clk/io_addr come from
// the slow I/O block and are treated as data; everything runs on clk.
module panel_debounce #(
  parameter int          DEBOUNCE_TICKS = 4,
  parameter logic [31:0] RESET_STABLE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_clk,
  input  logic [2:0]  io_addr,
  input  logic [3:0]  raw_switches,
  output logic [3:0]  io_switches,
  output logic [31:0] stable_bus,
  output logic        changed,
  output logic [2:0]  changed_slot
);

  localparam logic [3:0] TICKS = 4'(DEBOUNCE_TICKS);

  logic       io_clk_s1, io_clk_s2, io_clk_prev;
  logic [3:0] raw_s1, raw_s2;

  logic [3:0] stable [8];
  logic [3:0] cand   [8];
  logic [3:0] cnt    [8];

  logic       sample_ev;
  logic [3:0] cur_stable, cur_cand, cur_cnt;
  logic [3:0] cnt_next;
  logic       cand_load, accept;

  // Two-flop synchronisers of equal depth, plus a history flop for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_clk_s1   <= 1'b0;
      io_clk_s2   <= 1'b0;
      io_clk_prev <= 1'b0;
      raw_s1      <= 4'h0;
      raw_s2      <= 4'h0;
    end else begin
      io_clk_s1   <= io_clk;
      io_clk_s2   <= io_clk_s1;
      io_clk_prev <= io_clk_s2;
      raw_s1      <= raw_switches;
      raw_s2      <= raw_s1;
    end
  end

  // Sample on the falling scan edge, mid-period, when panel data has settled.
  // prev resets low so reset release can never look like a falling edge.
  assign sample_ev = ~io_clk_s2 & io_clk_prev;

  // Debounce decision for the addressed slot; accept folds the count back to 0.
  always_comb begin
    cur_stable = stable[io_addr];
    cur_cand   = cand[io_addr];
    cur_cnt    = cnt[io_addr];
    cand_load  = 1'b0;
    accept     = 1'b0;
    cnt_next   = 4'h0;
    if (raw_s2 == cur_stable) begin
      cnt_next = 4'h0;
    end else if (raw_s2 != cur_cand) begin
      cand_load = 1'b1;
      cnt_next  = 4'h1;
    end else begin
      cnt_next = cur_cnt + 4'h1;
    end
    if (raw_s2 != cur_stable && cnt_next == TICKS) begin
      accept   = 1'b1;
      cnt_next = 4'h0;
    end
  end

  // Per-slot state update; only the addressed slot moves on an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        stable[i] <= RESET_STABLE[4*i +: 4];
        cand[i]   <= RESET_STABLE[4*i +: 4];
        cnt[i]    <= 4'h0;
      end
      changed      <= 1'b0;
      changed_slot <= 3'd0;
    end else begin
      changed <= 1'b0;
      if (sample_ev) begin
        cnt[io_addr] <= cnt_next;
        if (cand_load) begin
          cand[io_addr] <= raw_s2;
        end
        if (accept) begin
          stable[io_addr] <= raw_s2;
          changed         <= 1'b1;
          changed_slot    <= io_addr;
        end
      end
    end
  end

  // Registered mux toward the I/O block; follows io_addr with one clk of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_switches <= RESET_STABLE[3:0];
    end else begin
      io_switches <= stable[io_addr];
    end
  end

  // Flat view of every slot's debounced nibble.
  always_comb begin
    stable_bus = '0;
    for (int i = 0; i < 8; i++) begin
      stable_bus[4*i +: 4] = stable[i];
    end
  end

endmodule

// File: doc/panel_debounce.md
# panel_debounce

Front-panel switch conditioner upstream of the I/O register block. It synchronises the raw multiplexed panel switch nibble and debounces each of the 8 scan slots independently. It then presents the stable nibble for the current scan address on `io_switches`, which the I/O block samples on each rising `io_clk`. It runs entirely in the system clock domain and treats `io_clk`/`io_addr` (produced by the I/O block) as slow data inputs.

## Interface
Parameters:
- `DEBOUNCE_TICKS`, 4: number of consecutive identical differing samples of a slot required to accept a new value. Legal range 1..15.
- `RESET_STABLE`, 32'hFFFF_0000: debounced value loaded at reset. Slot s occupies bits [4s+3:4s]. Slots 4-7 are the control switches, active-low, so they idle high.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `io_clk`, in, 1: panel scan clock from the I/O block (slow, asynchronous to sampling logic).
- `io_addr`, in, 3: current scan slot from the I/O block; changes only on rising `io_clk`.
- `raw_switches`, in, 4: undebounced panel switch lines for the currently addressed slot; asynchronous.
- `io_switches`, out, 4: debounced nibble of slot `io_addr`, to the I/O block.
- `stable_bus`, out, 32: all 8 debounced nibbles, with slot s at [4s+3:4s].
- `changed`, out, 1: one-cycle pulse when any slot's debounced value changes.
- `changed_slot`, out, 3: slot index that changed; valid while `changed`=1, otherwise holds its last value.

## Operation
- `io_clk` and `raw_switches` each pass through a 2-flop synchroniser of the same depth. A third `io_clk` register (`prev`) is used for edge detection.
- Sample event: synchronised `io_clk`=0 and `prev`=1, i.e. a falling edge at mid-scan-period when panel data has settled. Slot = `io_addr`, sampled directly; it is stable because it only changes on rising `io_clk`.
- Per-slot state: `stable[s]` (4b), `cand[s]` (4b), `cnt[s]` (4b, saturating-free, range 0..DEBOUNCE_TICKS).
- On a sample event for slot s with sample value v:
  - v == `stable[s]`: `cnt[s]`<=0. `cand[s]` is unchanged.
  - v != `stable[s]` and v != `cand[s]`: `cand[s]`<=v, `cnt[s]`<=1. If DEBOUNCE_TICKS==1, accept immediately (see below).
  - v != `stable[s]` and v == `cand[s]`: `cnt[s]`<=`cnt[s]`+1.
  - Accept: when the new count equals DEBOUNCE_TICKS, `stable[s]`<=v, `cnt[s]`<=0, `changed`<=1, `changed_slot`<=s.
- Slots not addressed by the event are untouched. Only one slot updates per event, so events never collide.
- `io_switches` is registered every clk: `io_switches`<=`stable[io_addr]`. It tracks `io_addr` changes and stable updates.
- `stable_bus` is a direct view of the `stable` registers.

## Timing
- Reset (asynchronous, immediate):
  - `stable`=`RESET_STABLE`, `cand`=`RESET_STABLE` slots, all `cnt`=0.
  - Synchronisers and `prev` = 0.
  - `changed`=0, `changed_slot`=0.
  - `io_switches`=`RESET_STABLE` nibble 0 (4'h0).
- Let the falling edge of `io_clk` be seen at clk edge N (sync1).
  - sync2 falls at N+1; the event is decoded in the cycle after N+1.
  - `stable`/`cand`/`cnt`/`changed` update at edge N+2. `changed` is high for exactly one cycle.
  - `io_switches` reflects the new value at N+3.
- Latency from `io_addr` change to `io_switches` = 1 clk.
- A raw value needs DEBOUNCE_TICKS scan visits to its slot (every 8 `io_clk` periods) before acceptance.
- `io_clk` period is at least 8 clk. Faster `io_clk` is unsupported.
- Reset asserted mid-count discards all partial counts. After release, the first event is the first falling edge detected with `prev` already 1.
  - No spurious event occurs on reset release, because `prev`=0.

## Test plan
- Reset: assert `reset` with random inputs → `stable_bus`=32'hFFFF_0000, `io_switches`=4'h0, `changed`=0, asynchronously (before any clk edge).
- Clean press, TICKS=4: slot 2 raw=4'hA held → `stable_bus`[11:8] becomes 4'hA at the 4th slot-2 event. `changed` is a single pulse with `changed_slot`=2. No other nibble changes.
- Bounce: slot 5 raw goes 4'hE for 3 events, then back to 4'hF → no `changed`, `stable_bus`[23:20] stays 4'hF, and `cnt[5]` returns to 0.
- Candidate switch: slot 0 gets 4'h1,4'h1,4'h3,4'h3,4'h3,4'h3 → accepts 4'h3 only on the 6th event. 4'h1 is never accepted.
- Reset mid-count: 3 matching events of 4'h7 on slot 1, then pulse `reset`, then 3 more events → `stable_bus`[7:4] still 4'h0. The 4th post-reset event accepts 4'h7.
- Mux/handshake: preload distinct values in all slots, then step `io_addr` 0..7 → `io_switches` equals each slot's value 1 clk after each `io_addr` change, and is stable at every rising `io_clk`. Repeat with TICKS=1, where every differing sample is accepted on its first event.
